conf_write: RTL

Configuration write-back engine: the transmit-side counterpart of the configuration loader. After `start`, it streams the stored configuration out through the 512-bit output write queue. It first emits the initial-configuration header word, then reads every configuration memory entry in address order, zero-extends each 352-bit entry to 512 bits and emits it. The host uses it to dump and check the CGRA configuration memory.

---
 rtl/conf_write.sv | 129 ++++++++++++
 1 files changed

// File: rtl/conf_write.sv
// conf_write: configuration write-back engine.
// On start, emits the initial-configuration header word, then reads each
// configuration memory entry in address order and emits it zero-extended
// from 352 to 512 bits. done is sticky until reset.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; latches the saturated entry count
// S_HDR   | waiting for queue space to emit the header word
// S_FETCH | all entries sent -> S_DONE, else issue a memory read
// S_MEMW  | read in flight (conf_rd_en high this cycle)
// S_CAP   | conf_in valid; capture it into the entry buffer
// S_SEND  | waiting for queue space to emit the buffered entry
// S_DONE  | dump complete; done held high until reset
module conf_write (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [31:0]  num_conf,
  input  logic [511:0] initial_conf,
  input  logic         available_write,
  output logic         req_wr_data,
  output logic [511:0] wr_data,
  output logic         conf_rd_en,
  output logic [9:0]   conf_rd_addr,
  input  logic [351:0] conf_in,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_MEMW,
    S_CAP,
    S_SEND,
    S_DONE
  } state_t;

  state_t       state_q;
  logic [10:0]  cont_q;
  logic [10:0]  cont_d;
  logic [10:0]  count_q;
  logic [10:0]  count_d;
  logic [351:0] buf_q;
  logic         req_q;
  logic [511:0] wr_data_q;
  logic         rd_en_q;
  logic [9:0]   rd_addr_q;
  logic         done_q;

  // Saturate the requested entry count to the memory depth; the entry
  // counter is 11 bits so that 1024 is representable and the address never wraps.
  always_comb begin
    count_d = (num_conf > 32'd1024) ? 11'd1024 : num_conf[10:0];
    cont_d  = cont_q + 11'd1;
  end

  // Sequencer: header, then one fetch/wait/capture/send round per entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cont_q    <= 11'd0;
      count_q   <= 11'd0;
      buf_q     <= 352'd0;
      req_q     <= 1'b0;
      wr_data_q <= 512'd0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= 10'd0;
      done_q    <= 1'b0;
    end else begin
      req_q   <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            count_q <= count_d;
            cont_q  <= 11'd0;
            state_q <= S_HDR;
          end
        end
        S_HDR: begin
          if (available_write) begin
            req_q     <= 1'b1;
            wr_data_q <= initial_conf;
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (cont_q >= count_q) begin
            state_q <= S_DONE;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= cont_q[9:0];
            state_q   <= S_MEMW;
          end
        end
        S_MEMW: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          buf_q   <= conf_in;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (available_write) begin
            req_q     <= 1'b1;
            wr_data_q <= {160'd0, buf_q};
            cont_q    <= cont_d;
            state_q   <= S_FETCH;
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_wr_data  = req_q;
  assign wr_data      = wr_data_q;
  assign conf_rd_en   = rd_en_q;
  assign conf_rd_addr = rd_addr_q;
  assign done         = done_q;

endmodule
